load_align_unit: RTL and testbench

- Read-side counterpart of the store byte-enable logic in the MEM stage.
- Issues word-aligned reads to the synchronous-read data memory, whose data arrives one cycle after the read.
- Extracts the addressed byte or halfword from the returned word and sign- or zero-extends it to 32 bits.
- Holds the result in a registered output stage with a downstream stall handshake. A one-word skid buffer ensures returned RAM data is never lost while stalled.

---
 rtl/load_align_unit.sv | 178 +++++++++++++++++
 tb/tb_load_align_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_unit
//  Description : MEM-stage load path. Issues word-aligned reads to a
//                synchronous-read data RAM, then extracts the addressed
//                byte/halfword/word from the returned data and sign- or
//                zero-extends it into a registered output stage that obeys
//                a downstream stall. A one-word skid register keeps the RAM
//                word for a pending load that cannot advance, because the
//                RAM output is only valid for one cycle.
//
//  Ports       : clk, reset (sync, active-high)
//                req_valid/req_ready/load_op/addr : load request handshake
//                mem_ren/mem_addr/mem_rdata       : data RAM read port
//                stall/out_valid/load_data/misalign : result stage
//
//  Optional    : `define LOAD_MISALIGN_CHK_EN enables the alignment check
//                for LH/LHU/LW. A misaligned access reports misalign = 1
//                and returns zero data. Without it misalign is tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align_unit #(
    parameter logic [5:0] LB_OP  = 6'b100000,
    parameter logic [5:0] LBU_OP = 6'b100100,
    parameter logic [5:0] LH_OP  = 6'b100001,
    parameter logic [5:0] LHU_OP = 6'b100101,
    parameter logic [5:0] LW_OP  = 6'b100011
) (
    input  logic        clk,
    input  logic        reset,
    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  load_op,
    input  logic [31:0] addr,
    // data RAM read port
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    // result side
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] load_data,
    output logic        misalign
);

    // ------------------------------------------------------------------
    // Stage S1 (pending) and S2 (output) registers
    // ------------------------------------------------------------------
    logic        r_p_valid;
    logic [5:0]  r_p_op;
    logic [1:0]  r_p_off;
    logic [31:0] r_raw_buf;
    logic        r_raw_buf_valid;

    logic        r_out_valid;
    logic [31:0] r_load_data;
    logic        r_misalign;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic        w_s2_free;
    logic        w_accept;
    logic        w_advance;
    logic        w_capture;

    assign w_s2_free = ~r_out_valid | ~stall;
    assign req_ready = ~r_p_valid | w_s2_free;
    assign w_accept  = req_valid & req_ready;
    assign w_advance = r_p_valid & w_s2_free;
    // The RAM word is only on mem_rdata in the first cycle the load sits in
    // S1; if it cannot advance then, park the word in the skid register.
    assign w_capture = r_p_valid & ~w_s2_free & ~r_raw_buf_valid;

    assign mem_ren   = w_accept;
    assign mem_addr  = {addr[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Extraction / extension
    // ------------------------------------------------------------------
    logic [31:0] w_src;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext_data;
    logic        w_ext_mis;

    assign w_src = r_raw_buf_valid ? r_raw_buf : mem_rdata;

    always_comb begin
        w_byte = w_src[7:0];
        case (r_p_off)
            2'd0:    w_byte = w_src[7:0];
            2'd1:    w_byte = w_src[15:8];
            2'd2:    w_byte = w_src[23:16];
            default: w_byte = w_src[31:24];
        endcase
    end

    assign w_half = r_p_off[1] ? w_src[31:16] : w_src[15:0];

    always_comb begin
        w_ext_data = w_src;
        w_ext_mis  = 1'b0;
        case (r_p_op)
            LB_OP:   w_ext_data = {{24{w_byte[7]}}, w_byte};
            LBU_OP:  w_ext_data = {24'h000000, w_byte};
            LH_OP:   w_ext_data = {{16{w_half[15]}}, w_half};
            LHU_OP:  w_ext_data = {16'h0000, w_half};
            default: w_ext_data = w_src;
        endcase
`ifdef LOAD_MISALIGN_CHK_EN
        if ((r_p_op == LH_OP) || (r_p_op == LHU_OP)) begin
            w_ext_mis = r_p_off[0];
        end else if (r_p_op == LW_OP) begin
            w_ext_mis = (r_p_off != 2'd0);
        end
        // A faulting load never returns partial data.
        if (w_ext_mis) begin
            w_ext_data = 32'h0000_0000;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Stage S1
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_valid       <= 1'b0;
            r_p_op          <= 6'd0;
            r_p_off         <= 2'd0;
            r_raw_buf       <= 32'h0000_0000;
            r_raw_buf_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                // Accept may coincide with the previous load advancing.
                r_p_valid       <= 1'b1;
                r_p_op          <= load_op;
                r_p_off         <= addr[1:0];
                r_raw_buf_valid <= 1'b0;
            end else if (w_advance) begin
                r_p_valid       <= 1'b0;
                r_raw_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_raw_buf       <= mem_rdata;
                r_raw_buf_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage S2
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_load_data <= 32'h0000_0000;
            r_misalign  <= 1'b0;
        end else begin
            if (w_advance) begin
                r_out_valid <= 1'b1;
                r_load_data <= w_ext_data;
                r_misalign  <= w_ext_mis;
            end else if (w_s2_free) begin
                // Current result consumed (or none present) and nothing new.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign load_data = r_load_data;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_align_unit
//  Description : Self-checking bench for load_align_unit. Expected results
//                are queued at request acceptance from a reference model of
//                the load rules and compared by an independent monitor when
//                the DUT hands a result downstream. The RAM model drives
//                random junk on cycles that follow no read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_align_unit;

    localparam logic [5:0] C_LB  = 6'b100000;
    localparam logic [5:0] C_LBU = 6'b100100;
    localparam logic [5:0] C_LH  = 6'b100001;
    localparam logic [5:0] C_LHU = 6'b100101;
    localparam logic [5:0] C_LW  = 6'b100011;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  load_op;
    logic [31:0] addr;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        out_valid;
    logic [31:0] load_data;
    logic        misalign;

    load_align_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .load_op   (load_op),
        .addr      (addr),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .out_valid (out_valid),
        .load_data (load_data),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [31:0] mem [256];
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? mem[mem_addr[9:2]] : $urandom;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking infrastructure ----------------
    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        nchecks++;
        nerrors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: {misalign, data} from the load rules.
    function automatic logic [32:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] w);
        int unsigned off;
        longint      b, h, d;
        logic        mis;
        off = a % 4;
        b   = longint'((w >> (8 * off)) & 32'h0000_00FF);
        h   = longint'((w >> (16 * (off / 2))) & 32'h0000_FFFF);
        mis = 1'b0;
        case (op)
            C_LB:    d = (b >= 128) ? b - 256 : b;
            C_LBU:   d = b;
            C_LH: begin
                d = (h >= 32768) ? h - 65536 : h;
`ifdef LOAD_MISALIGN_CHK_EN
                mis = (off % 2) != 0;
`endif
            end
            C_LHU: begin
                d = h;
`ifdef LOAD_MISALIGN_CHK_EN
                mis = (off % 2) != 0;
`endif
            end
            C_LW: begin
                d = longint'(w);
`ifdef LOAD_MISALIGN_CHK_EN
                mis = off != 0;
`endif
            end
            default: d = longint'(w);
        endcase
        if (mis) d = 0;
        return {mis, d[31:0]};
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    int last_acc_cyc = 0;
    int last_pop_cyc = 0;
    int prev_pop_cyc = 0;

    logic        hold_chk = 1'b0;
    logic [31:0] hold_data;
    logic        hold_mis;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                logic [32:0] m;
                exp_t e;
                m      = model(load_op, addr, mem[addr[9:2]]);
                e.data = m[31:0];
                e.mis  = m[32];
                sb.push_back(e);
                last_acc_cyc = cyc;
            end
            if (mem_ren !== (req_valid & req_ready))
                check("mem_ren", {31'b0, mem_ren}, {31'b0, req_valid & req_ready});
            if (mem_ren)
                check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (hold_chk) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", load_data, hold_data);
                check("hold_mis", {31'b0, misalign}, {31'b0, hold_mis});
            end
            if (out_valid && !stall) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("load_data", load_data, e.data);
                    check("misalign", {31'b0, misalign}, {31'b0, e.mis});
                end
                prev_pop_cyc = last_pop_cyc;
                last_pop_cyc = cyc;
            end
            hold_chk  = out_valid && stall;
            hold_data = load_data;
            hold_mis  = misalign;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [5:0] op, input logic [31:0] a, output int waits);
        req_valid = 1'b1;
        load_op   = op;
        addr      = a;
        waits     = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!req_ready && waits < 50);
        if (!req_ready) fail_now("send_accept");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        stall     = 1'b0;
        req_valid = 1'b0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain");
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w, w2, n;
        logic acc;
        logic [5:0] ops [6];

        clk = 1'b0; reset = 1'b1; req_valid = 1'b0; load_op = '0; addr = '0; stall = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = 32'h80FF_1234;   // LB/LBU at 0x03
        mem[8]  = 32'h8001_7FFF;   // LH at 0x22, LHU at 0x20
        mem[12] = 32'hAABB_CCDD;   // LBU at 0x31 under stall
        mem[16] = 32'h1357_9BDF;   // LW at offset 2

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // LB / LBU at byte 3, with latency check on the first one
        send(C_LB, 32'h0000_0003, w);
        req_valid = 1'b0;
        drain();
        check("latency", 32'(last_pop_cyc - last_acc_cyc), 32'd2);
        send(C_LBU, 32'h0000_0003, w);
        send(C_LH, 32'h0000_0022, w);
        send(C_LHU, 32'h0000_0020, w);
        drain();

        // back-to-back words
        send(C_LW, 32'h0000_0010, w);
        send(C_LW, 32'h0000_0014, w2);
        req_valid = 1'b0;
        check("b2b_ready", 32'(w2), 32'd1);
        drain();
        check("b2b_consecutive", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);

        // stall with a pending LBU whose RAM word must come from the skid
        stall = 1'b1;
        send(C_LW, 32'h0000_0050, w);
        send(C_LBU, 32'h0000_0031, w);
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) fail_now("stall_out_valid");
        check("stall_ready0", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        drain();

        // word load at offset 2
        send(C_LW, 32'h0000_0042, w);
        drain();

        // reset in the cycle after an accept
        send(C_LB, 32'h0000_0003, w);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
            check("rst_flush_data", load_data, 32'd0);
        end
        @(posedge clk); #1;

        // randomized traffic with random stalls
        acc = 1'b1;
        for (int i = 0; i < 500; i++) begin
            ops[0] = C_LB; ops[1] = C_LBU; ops[2] = C_LH;
            ops[3] = C_LHU; ops[4] = C_LW; ops[5] = 6'($urandom);
            if (!req_valid || acc) begin
                req_valid = ($urandom % 4) != 0;
                load_op   = ops[$urandom % 6];
                addr      = $urandom % 1024;
            end
            stall = ($urandom % 10) < 3;
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk); #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
